// File: rtl/timer_arbiter_pkg.sv
// Shared types and helpers for the timer arbiter: FSM encoding, round-robin pick, one-hot decode.
package timer_arbiter_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // First set bit strictly after `last`, wrapping modulo n; returns `last` if nothing is set.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   last,
                                                input logic [3:0]         n);
    logic [IDX_W-1:0] win;
    logic             found;
    logic [3:0]       idx;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = {1'b0, last} + 4'(i);
      if (idx >= n) idx = idx - n;
      if (!found && (4'(i) <= n) && req[idx[IDX_W-1:0]]) begin
        win   = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/timer_arbiter_counter.sv
// Saturating up-counter that stops when it reaches the limit; hit flags equality.
// Clear has priority over enable.
module delay_counter #(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [BITS-1:0] limit,
  output logic [BITS-1:0] count,
  output logic            hit
);

  assign hit = (count == limit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !hit) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin owner of one shared delay counter; grants one requester, counts tick_en, pulses done.
// Grant one cycle after request; all outputs registered.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*BITS-1:0] delay_i,
  input  logic                  tick_en,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic                  busy,
  output logic [BITS-1:0]       count_o
);

  state_t             state;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   pick;
  logic [BITS-1:0]    limit;
  logic [BITS-1:0]    dly_pick;
  logic [MAX_REQ-1:0] req_ext;
  logic               hit;
  logic               cnt_clear;
  logic               cnt_en;

  always_comb begin
    req_ext = '0;
    req_ext[N_REQ-1:0] = req;
  end

  assign pick = rr_pick(req_ext, last, 4'(N_REQ));

  always_comb begin
    dly_pick = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick == IDX_W'(k)) dly_pick = delay_i[k*BITS +: BITS];
    end
  end

  // Expiry outranks a cancel, so the count is only cleared on a drop when not at the limit.
  assign cnt_clear = (state != RUN) || (!hit && !req_ext[win]);
  assign cnt_en    = (state == RUN) && req_ext[win] && tick_en;

  delay_counter #(.BITS(BITS)) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .limit  (limit),
    .count  (count_o),
    .hit    (hit)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
      win   <= '0;
      last  <= IDX_W'(N_REQ-1);
      limit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= RUN;
            win   <= pick;
            grant <= N_REQ'(onehot(pick));
            limit <= dly_pick;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (hit) begin
            state <= DONE;
            done  <= grant;
          end else if (!req_ext[win]) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            last  <= win;
          end
        end
        DONE: begin
          state <= IDLE;
          grant <= '0;
          done  <= '0;
          busy  <= 1'b0;
          last  <= win;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Scenario bench for timer_arbiter: per-cycle expected outputs queued up front, popped as cycles elapse.
module tb_timer_arbiter;

  localparam int N = 4;
  localparam int B = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*B-1:0] delay_i = '0;
  logic         tick_en = 1'b0;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic         busy;
  logic [B-1:0] count_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] d;
    logic       b;
  } exp_t;

  exp_t sb[$];

  timer_arbiter #(.N_REQ(N), .BITS(B)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .delay_i (delay_i),
    .tick_en (tick_en),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_delay(input int k, input logic [B-1:0] v);
    delay_i[k*B +: B] = v;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req = '0;
    tick_en = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 4'b1111;
    repeat (3) step();
    tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b want 0000", grant); end
    tests++; if (done !== 4'b0000) begin fails++; $display("FAIL reset_done: got %b want 0000", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (count_o !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count_o); end
    reset = 1'b1;
    req = '0;
    step();
  endtask

  task automatic test_single();
    exp_t e;
    int n = 0;
    int done_c = 0;
    apply_reset();
    set_delay(0, 16'd3);
    for (int c = 1; c <= 10; c++) begin
      e.g = (done_c == 0 || c <= done_c) ? 4'b0001 : 4'b0000;
      e.d = (c == done_c) ? 4'b0001 : 4'b0000;
      e.b = (e.g != 4'b0000);
      sb.push_back(e);
      if ((c % 2 == 1) && n < 3) begin
        n++;
        if (n == 3) done_c = c + 2;
      end
    end
    req = 4'b0001;
    tick_en = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      e = sb.pop_front();
      tests++; if (grant !== e.g) begin fails++; $display("FAIL single_grant c%0d: got %b want %b", c, grant, e.g); end
      tests++; if (done !== e.d) begin fails++; $display("FAIL single_done c%0d: got %b want %b", c, done, e.d); end
      tests++; if (busy !== e.b) begin fails++; $display("FAIL single_busy c%0d: got %b want %b", c, busy, e.b); end
      if (c == done_c) begin
        tests++; if (count_o !== 16'd3) begin fails++; $display("FAIL single_count: got %0d want 3", count_o); end
        req = 4'b0000;
      end
      tick_en = (c % 2 == 1);
    end
    tick_en = 1'b0;
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [3:0] prev = 4'b0000;
    int last_c = 0;
    int c = 0;
    apply_reset();
    for (int k = 0; k < N; k++) set_delay(k, 16'd1);
    e.d = 4'b0000; e.b = 1'b1;
    e.g = 4'b0001; sb.push_back(e);
    e.g = 4'b0010; sb.push_back(e);
    e.g = 4'b0100; sb.push_back(e);
    e.g = 4'b1000; sb.push_back(e);
    e.g = 4'b0001; sb.push_back(e);
    tick_en = 1'b1;
    req = 4'b1111;
    while (sb.size() > 0 && c < 40) begin
      step();
      c++;
      if (done !== 4'b0000) begin
        tests++; if (done !== grant) begin fails++; $display("FAIL rr_done_owner c%0d: got %b want %b", c, done, grant); end
      end
      if (grant !== 4'b0000 && prev === 4'b0000) begin
        e = sb.pop_front();
        tests++; if (grant !== e.g) begin fails++; $display("FAIL rr_order c%0d: got %b want %b", c, grant, e.g); end
        if (last_c > 0) begin
          tests++; if (c - last_c != 4) begin fails++; $display("FAIL rr_spacing c%0d: got %0d want 4", c, c - last_c); end
        end
        last_c = c;
      end
      prev = grant;
    end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL rr_timeout: got %0d pending want 0", sb.size()); sb.delete(); end
    req = 4'b0000;
    c = 0;
    while (busy !== 1'b0 && c < 10) begin step(); c++; end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_idle: got busy %b want 0", busy); end
    tick_en = 1'b0;
  endtask

  task automatic test_delay_zero();
    exp_t e;
    apply_reset();
    set_delay(2, 16'd0);
    tick_en = 1'b0;
    e = '{g: 4'b0100, d: 4'b0000, b: 1'b1}; sb.push_back(e);
    e = '{g: 4'b0100, d: 4'b0100, b: 1'b1}; sb.push_back(e);
    e = '{g: 4'b0000, d: 4'b0000, b: 1'b0}; sb.push_back(e);
    e = '{g: 4'b0100, d: 4'b0000, b: 1'b1}; sb.push_back(e);
    e = '{g: 4'b0100, d: 4'b0100, b: 1'b1}; sb.push_back(e);
    e = '{g: 4'b0000, d: 4'b0000, b: 1'b0}; sb.push_back(e);
    req = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      step();
      e = sb.pop_front();
      tests++; if (grant !== e.g) begin fails++; $display("FAIL d0_grant c%0d: got %b want %b", c, grant, e.g); end
      tests++; if (done !== e.d) begin fails++; $display("FAIL d0_done c%0d: got %b want %b", c, done, e.d); end
      tests++; if (busy !== e.b) begin fails++; $display("FAIL d0_busy c%0d: got %b want %b", c, busy, e.b); end
      if (c == 2) begin
        tests++; if (count_o !== 16'd0) begin fails++; $display("FAIL d0_count: got %0d want 0", count_o); end
      end
      if (c == 4) req = 4'b0000;
    end
  endtask

  task automatic test_cancel();
    exp_t e;
    apply_reset();
    set_delay(1, 16'd10);
    set_delay(2, 16'd2);
    e = '{g: 4'b0010, d: 4'b0000, b: 1'b1}; repeat (3) sb.push_back(e);
    e = '{g: 4'b0000, d: 4'b0000, b: 1'b0}; sb.push_back(e);
    e = '{g: 4'b0100, d: 4'b0000, b: 1'b1}; repeat (3) sb.push_back(e);
    e = '{g: 4'b0100, d: 4'b0100, b: 1'b1}; sb.push_back(e);
    e = '{g: 4'b0000, d: 4'b0000, b: 1'b0}; sb.push_back(e);
    tick_en = 1'b1;
    req = 4'b0010;
    for (int c = 1; c <= 9; c++) begin
      step();
      e = sb.pop_front();
      tests++; if (grant !== e.g) begin fails++; $display("FAIL cancel_grant c%0d: got %b want %b", c, grant, e.g); end
      tests++; if (done !== e.d) begin fails++; $display("FAIL cancel_done c%0d: got %b want %b", c, done, e.d); end
      tests++; if (busy !== e.b) begin fails++; $display("FAIL cancel_busy c%0d: got %b want %b", c, busy, e.b); end
      if (c == 3) req = 4'b0100;
      if (c == 7) req = 4'b0000;
    end
    tick_en = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    set_delay(2, 16'd20);
    tick_en = 1'b1;
    req = 4'b0100;
    repeat (6) step();
    tests++; if (count_o !== 16'd5) begin fails++; $display("FAIL mid_count_pre: got %0d want 5", count_o); end
    tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL mid_grant_pre: got %b want 0100", grant); end
    reset = 1'b0;
    step();
    tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL mid_grant: got %b want 0000", grant); end
    tests++; if (count_o !== 16'd0) begin fails++; $display("FAIL mid_count: got %0d want 0", count_o); end
    tests++; if (done !== 4'b0000) begin fails++; $display("FAIL mid_done: got %b want 0000", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
    reset = 1'b1;
    tick_en = 1'b0;
    req = 4'b1111;
    step();
    tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL mid_pointer: got %b want 0001", grant); end
    req = 4'b0000;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_delay_zero();
    test_cancel();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
